ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 4, RAM address width.
REQ-002 Parameter DATA_WIDTH, default 8, RAM data width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-low reset.
REQ-005 req0, req1  input  1 each  requester N access request; held with its command until gntN.
REQ-006 wr_enb0, wr_enb1  input  1 each  requester N operation: 1 = write, 0 = read.
REQ-007 addr0, addr1  input  ADDR_WIDTH each  requester N address.
REQ-008 wr_data0, wr_data1  input  DATA_WIDTH each  requester N write data.
REQ-009 gnt0, gnt1  output  1 each  one-cycle pulse; requester N's command has been latched.
REQ-010 rvalid0, rvalid1  output  1 each  one-cycle pulse; rd_dataN holds read result.
REQ-011 rd_data0, rd_data1  output  DATA_WIDTH each  read result for requester N; holds last value between reads.
REQ-012 ram_wr_enb, ram_rd_enb  output  1 each  RAM write/read strobes.
REQ-013 ram_addr  output  ADDR_WIDTH  RAM address.
REQ-014 ram_wr_data  output  DATA_WIDTH  RAM write data.
REQ-015 ram_rd_data  input  DATA_WIDTH  RAM read data, valid one cycle after ram_rd_enb sampled.
REQ-016 busy  output  1  high whenever state is not IDLE.

Function
REQ-017 FSM states IDLE, ACCESS, RD_WAIT; all outputs registered.
REQ-018 IDLE, no req: remain IDLE; ram strobes 0.
REQ-019 IDLE, any req: select winner; on that edge load ram_addr, ram_wr_data, ram_wr_enb = winner wr_enb, ram_rd_enb = ~winner wr_enb; set gnt of winner = 1; go ACCESS.
REQ-020 ACCESS (one cycle): RAM samples strobes; on the exiting edge clear strobes and gnt; go RD_WAIT if read, else IDLE.
REQ-021 RD_WAIT (one cycle): on exiting edge capture ram_rd_data into rd_dataN of winner, pulse rvalidN for one cycle, go IDLE.
REQ-022 Latency: write = 2 cycles req-sample to IDLE; read = rvalid 3 edges after req sampled in IDLE.
REQ-023 Requests arriving while busy are not sampled; requester holds req until gnt.
REQ-024 Requester may drop req in the gnt cycle; a req still high on the edge returning to IDLE is a new request (back-to-back allowed).
REQ-025 Round-robin: with both req high, grant the requester not granted last; single requester always wins.
REQ-026 Last-grant pointer updates only on a grant; reset value points at requester 1, so requester 0 wins the first contention.
REQ-027 ram_addr and ram_wr_data hold last values when idle; only strobes return to 0.
REQ-028 gnt0 and gnt1 never high in the same cycle; rvalid0 and rvalid1 never high in the same cycle.

Reset
REQ-029 rst = 0 at a rising edge forces IDLE and clears gnt*, rvalid*, rd_data*, ram_wr_enb, ram_rd_enb, ram_addr, ram_wr_data, busy to 0; pointer to requester 1.
REQ-030 Reset mid-operation (ACCESS or RD_WAIT) aborts it; no rvalid is issued for the aborted read.

Configuration
REQ-031 Macro RAM_ARB_FIXED_PRI_EN: when defined, requester 0 always wins contention and the pointer is unused; when undefined, round-robin per REQ-025/026.

Verification
REQ-032 Reset: rst = 0 for 2 cycles with req0 = 1 -> all outputs 0, no gnt during reset.
REQ-033 Write then read: req0 write addr 3 data 0xA5; then req0 read addr 3 -> gnt0 pulses twice, rvalid0 = 1 with rd_data0 = 0xA5, 3 edges after the read req is sampled.
REQ-034 Contention: req0 and req1 both write (addr 1 = 0x11, addr 2 = 0x22) held high -> gnt0 first, then gnt1; RAM holds both values.
REQ-035 Fairness: both req held continuously for 6 grants -> grants alternate 0,1,0,1,0,1; with RAM_ARB_FIXED_PRI_EN defined -> requester 0 gets all 6 grants.
REQ-036 Reset abort: rst = 0 during RD_WAIT of a req1 read -> no rvalid1; busy = 0 on the next cycle.
REQ-037 Back-to-back: req1 held high for three writes -> gnt1 every 2 cycles; busy stays high except the single IDLE cycles.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous RAM; round-robin on contention.
// Define RAM_ARB_FIXED_PRI_EN to give requester 0 fixed priority instead.
module ram_arbiter #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  wr_enb0,
  input  logic                  wr_enb1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wr_data0,
  input  logic [DATA_WIDTH-1:0] wr_data1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rd_data0,
  output logic [DATA_WIDTH-1:0] rd_data1,
  output logic                  ram_wr_enb,
  output logic                  ram_rd_enb,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic                  busy
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RD_WAIT = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_sel;
  logic                  w_sel_nxt;
  logic                  r_rd;
  logic                  w_rd_nxt;
  logic                  w_win;
  logic                  r_gnt0, r_gnt1, w_gnt0_nxt, w_gnt1_nxt;
  logic                  r_rvalid0, r_rvalid1, w_rvalid0_nxt, w_rvalid1_nxt;
  logic [DATA_WIDTH-1:0] r_rd_data0, r_rd_data1, w_rd_data0_nxt, w_rd_data1_nxt;
  logic                  r_ram_wr_enb, r_ram_rd_enb, w_ram_wr_enb_nxt, w_ram_rd_enb_nxt;
  logic [ADDR_WIDTH-1:0] r_ram_addr, w_ram_addr_nxt;
  logic [DATA_WIDTH-1:0] r_ram_wr_data, w_ram_wr_data_nxt;
  logic                  r_busy, w_busy_nxt;

`ifdef RAM_ARB_FIXED_PRI_EN
  assign w_win = ~req0;
`else
  // Last-granted pointer: 1 means requester 1 was granted last.
  logic r_last;
  logic w_last_nxt;

  assign w_win = (req0 & req1) ? ~r_last : req1;
`endif

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt       = r_state;
    w_sel_nxt         = r_sel;
    w_rd_nxt          = r_rd;
    w_gnt0_nxt        = 1'b0;
    w_gnt1_nxt        = 1'b0;
    w_rvalid0_nxt     = 1'b0;
    w_rvalid1_nxt     = 1'b0;
    w_rd_data0_nxt    = r_rd_data0;
    w_rd_data1_nxt    = r_rd_data1;
    w_ram_wr_enb_nxt  = 1'b0;
    w_ram_rd_enb_nxt  = 1'b0;
    w_ram_addr_nxt    = r_ram_addr;
    w_ram_wr_data_nxt = r_ram_wr_data;
`ifndef RAM_ARB_FIXED_PRI_EN
    w_last_nxt        = r_last;
`endif

    case (r_state)
      ST_IDLE: begin
        if (req0 | req1) begin
          w_sel_nxt         = w_win;
          w_rd_nxt          = w_win ? ~wr_enb1 : ~wr_enb0;
          w_ram_addr_nxt    = w_win ? addr1 : addr0;
          w_ram_wr_data_nxt = w_win ? wr_data1 : wr_data0;
          w_ram_wr_enb_nxt  = w_win ? wr_enb1 : wr_enb0;
          w_ram_rd_enb_nxt  = w_win ? ~wr_enb1 : ~wr_enb0;
          w_gnt0_nxt        = ~w_win;
          w_gnt1_nxt        = w_win;
`ifndef RAM_ARB_FIXED_PRI_EN
          w_last_nxt        = w_win;
`endif
          w_state_nxt       = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        w_state_nxt = r_rd ? ST_RD_WAIT : ST_IDLE;
      end
      ST_RD_WAIT: begin
        if (r_sel) begin
          w_rd_data1_nxt = ram_rd_data;
          w_rvalid1_nxt  = 1'b1;
        end else begin
          w_rd_data0_nxt = ram_rd_data;
          w_rvalid0_nxt  = 1'b1;
        end
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_sel         <= 1'b0;
      r_rd          <= 1'b0;
      r_gnt0        <= 1'b0;
      r_gnt1        <= 1'b0;
      r_rvalid0     <= 1'b0;
      r_rvalid1     <= 1'b0;
      r_rd_data0    <= '0;
      r_rd_data1    <= '0;
      r_ram_wr_enb  <= 1'b0;
      r_ram_rd_enb  <= 1'b0;
      r_ram_addr    <= '0;
      r_ram_wr_data <= '0;
      r_busy        <= 1'b0;
`ifndef RAM_ARB_FIXED_PRI_EN
      r_last        <= 1'b1;
`endif
    end else begin
      r_state       <= w_state_nxt;
      r_sel         <= w_sel_nxt;
      r_rd          <= w_rd_nxt;
      r_gnt0        <= w_gnt0_nxt;
      r_gnt1        <= w_gnt1_nxt;
      r_rvalid0     <= w_rvalid0_nxt;
      r_rvalid1     <= w_rvalid1_nxt;
      r_rd_data0    <= w_rd_data0_nxt;
      r_rd_data1    <= w_rd_data1_nxt;
      r_ram_wr_enb  <= w_ram_wr_enb_nxt;
      r_ram_rd_enb  <= w_ram_rd_enb_nxt;
      r_ram_addr    <= w_ram_addr_nxt;
      r_ram_wr_data <= w_ram_wr_data_nxt;
      r_busy        <= w_busy_nxt;
`ifndef RAM_ARB_FIXED_PRI_EN
      r_last        <= w_last_nxt;
`endif
    end
  end

  assign gnt0        = r_gnt0;
  assign gnt1        = r_gnt1;
  assign rvalid0     = r_rvalid0;
  assign rvalid1     = r_rvalid1;
  assign rd_data0    = r_rd_data0;
  assign rd_data1    = r_rd_data1;
  assign ram_wr_enb  = r_ram_wr_enb;
  assign ram_rd_enb  = r_ram_rd_enb;
  assign ram_addr    = r_ram_addr;
  assign ram_wr_data = r_ram_wr_data;
  assign busy        = r_busy;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: vector table plus read-data scoreboard
// and hand-written multi-cycle sequences, against a behavioural synchronous RAM.
module tb_ram_arbiter;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;

  logic          clk;
  logic          rst;
  logic          req0, req1, wr_enb0, wr_enb1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wr_data0, wr_data1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rd_data0, rd_data1;
  logic          ram_wr_enb, ram_rd_enb;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wr_data, ram_rd_data;
  logic          busy;

  ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .wr_enb0(wr_enb0), .wr_enb1(wr_enb1),
    .addr0(addr0), .addr1(addr1), .wr_data0(wr_data0), .wr_data1(wr_data1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rd_data0(rd_data0), .rd_data1(rd_data1),
    .ram_wr_enb(ram_wr_enb), .ram_rd_enb(ram_rd_enb), .ram_addr(ram_addr),
    .ram_wr_data(ram_wr_data), .ram_rd_data(ram_rd_data), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural RAM: read data valid one cycle after the strobe is sampled.
  logic [DW-1:0] ram_mem [16];
  initial begin
    for (int i = 0; i < 16; i++) ram_mem[i] = '0;
    ram_rd_data = '0;
  end
  always @(posedge clk) begin
    if (ram_wr_enb) ram_mem[ram_addr] <= ram_wr_data;
    if (ram_rd_enb) ram_rd_data <= ram_mem[ram_addr];
  end

  int n_checks = 0;
  int n_errors = 0;
  logic [DW:0] sb_q[$];
  int          grant_log[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: grant log, mutual exclusion and read-data scoreboard.
  always @(negedge clk) begin
    if (gnt0 === 1'b1) grant_log.push_back(0);
    if (gnt1 === 1'b1) grant_log.push_back(1);
    if ((gnt0 | gnt1) === 1'b1) chk("gnt_excl", 64'(gnt0 & gnt1), 64'd0);
    if ((rvalid0 | rvalid1) === 1'b1) begin
      chk("rvalid_excl", 64'(rvalid0 & rvalid1), 64'd0);
      if (sb_q.size() == 0) begin
        chk("rvalid_unexpected", 64'({rvalid1, rvalid0}), 64'd0);
      end else begin
        logic [DW:0] e;
        e = sb_q.pop_front();
        chk("rd_result", 64'({rvalid1, rvalid1 ? rd_data1 : rd_data0}), 64'(e));
      end
    end
  end

  // Drive one command, wait for its grant, check the RAM bus, drop req in the gnt cycle.
  task automatic issue(input bit rq, input bit we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input bit push, input logic [DW-1:0] exp_d);
    int cyc;
    @(negedge clk);
    if (rq) begin req1 = 1'b1; wr_enb1 = we; addr1 = a; wr_data1 = d; end
    else    begin req0 = 1'b1; wr_enb0 = we; addr0 = a; wr_data0 = d; end
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if ((rq ? gnt1 : gnt0) === 1'b1) break;
      if (cyc > 40) begin
        chk("gnt_timeout", 64'(cyc), 64'd0);
        break;
      end
    end
    if (cyc <= 40) begin
      chk("bus_addr", 64'(ram_addr), 64'(a));
      chk("bus_strobes", 64'({ram_wr_enb, ram_rd_enb}), 64'({we, ~we}));
      if (we) chk("bus_wdata", 64'(ram_wr_data), 64'(d));
      chk("busy_access", 64'(busy), 64'd1);
      if (!we && push) sb_q.push_back({rq, exp_d});
    end
    if (rq) req1 = 1'b0; else req0 = 1'b0;
  endtask

  typedef struct {
    bit            rq;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] exp_rd;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int cnt, cyc, last_g;

    vecs[0] = '{1'b0, 1'b1, 4'h4, 8'h3C, 8'h00};
    vecs[1] = '{1'b1, 1'b1, 4'h5, 8'hC3, 8'h00};
    vecs[2] = '{1'b1, 1'b0, 4'h4, 8'h00, 8'h3C};
    vecs[3] = '{1'b0, 1'b0, 4'h5, 8'h00, 8'hC3};
    vecs[4] = '{1'b0, 1'b1, 4'h0, 8'hFF, 8'h00};
    vecs[5] = '{1'b1, 1'b1, 4'hF, 8'h81, 8'h00};
    vecs[6] = '{1'b0, 1'b0, 4'hF, 8'h00, 8'h81};
    vecs[7] = '{1'b1, 1'b0, 4'h0, 8'h00, 8'hFF};
    vecs[8] = '{1'b1, 1'b1, 4'h4, 8'h5A, 8'h00};
    vecs[9] = '{1'b0, 1'b0, 4'h4, 8'h00, 8'h5A};

    // Reset held two cycles with req0 asserted: everything stays zero.
    rst = 1'b0; req0 = 1'b1; wr_enb0 = 1'b1; addr0 = 4'h3; wr_data0 = 8'h77;
    req1 = 1'b0; wr_enb1 = 1'b0; addr1 = '0; wr_data1 = '0;
    #1;
    repeat (2) begin
      @(negedge clk);
      chk("reset_outputs", {gnt0, gnt1, rvalid0, rvalid1, rd_data0, rd_data1,
                            ram_wr_enb, ram_rd_enb, ram_addr, ram_wr_data, busy}, 64'd0);
    end
    rst = 1'b1; req0 = 1'b0;

    // First contention after reset: requester 0 then 1.
    grant_log.delete();
    fork
      issue(1'b0, 1'b1, 4'h1, 8'h11, 1'b0, 8'h00);
      issue(1'b1, 1'b1, 4'h2, 8'h22, 1'b0, 8'h00);
    join
    repeat (3) @(negedge clk);
    chk("cont_count", 64'(grant_log.size()), 64'd2);
    chk("cont_first", 64'(grant_log.size() > 0 ? grant_log[0] : 9), 64'd0);
    chk("cont_second", 64'(grant_log.size() > 1 ? grant_log[1] : 9), 64'd1);
    chk("cont_mem1", 64'(ram_mem[1]), 64'h11);
    chk("cont_mem2", 64'(ram_mem[2]), 64'h22);

    // Fairness: both held for six grants.
    grant_log.delete();
    @(negedge clk);
    req0 = 1'b1; wr_enb0 = 1'b1; addr0 = 4'h8; wr_data0 = 8'h80;
    req1 = 1'b1; wr_enb1 = 1'b1; addr1 = 4'h9; wr_data1 = 8'h90;
    cnt = 0; cyc = 0;
    while (cnt < 6 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if ((gnt0 | gnt1) === 1'b1) cnt++;
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("fair_count", 64'(grant_log.size()), 64'd6);
    for (int i = 0; i < 6; i++) begin
`ifdef RAM_ARB_FIXED_PRI_EN
      chk($sformatf("fair_%0d", i), 64'(i < grant_log.size() ? grant_log[i] : 9), 64'd0);
`else
      chk($sformatf("fair_%0d", i), 64'(i < grant_log.size() ? grant_log[i] : 9), 64'(i % 2));
`endif
    end

    // Write then read addr 3 with latency check.
    grant_log.delete();
    issue(1'b0, 1'b1, 4'h3, 8'hA5, 1'b0, 8'h00);
    issue(1'b0, 1'b0, 4'h3, 8'h00, 1'b1, 8'hA5);
    @(negedge clk);
    chk("rd_lat_early", 64'(rvalid0), 64'd0);
    @(negedge clk);
    chk("rd_lat_rvalid", 64'(rvalid0), 64'd1);
    chk("rd_lat_data", 64'(rd_data0), 64'hA5);
    chk("wr_rd_gnt0_count", 64'(grant_log.size()), 64'd2);

    // Table-driven single-requester traffic.
    for (int i = 0; i < 10; i++)
      issue(vecs[i].rq, vecs[i].we, vecs[i].addr, vecs[i].data, 1'b1, vecs[i].exp_rd);
    repeat (4) @(negedge clk);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    // Back-to-back writes from requester 1.
    @(negedge clk);
    req1 = 1'b1; wr_enb1 = 1'b1; addr1 = 4'h5; wr_data1 = 8'h50;
    cnt = 0; cyc = 0; last_g = 0;
    while (cnt < 3 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (gnt1 === 1'b1) begin
        cnt++;
        if (cnt > 1) chk("b2b_gap", 64'(cyc - last_g), 64'd2);
        chk("b2b_busy_gnt", 64'(busy), 64'd1);
        last_g = cyc;
        addr1 = addr1 + 4'(1);
        wr_data1 = wr_data1 + 8'(1);
        if (cnt == 3) req1 = 1'b0;
      end else if (cnt > 0) begin
        chk("b2b_busy_idle", 64'(busy), 64'd0);
      end
    end
    chk("b2b_count", 64'(cnt), 64'd3);
    repeat (2) @(negedge clk);
    chk("b2b_mem7", 64'(ram_mem[7]), 64'h52);

    // Reset during RD_WAIT of a requester-1 read aborts it.
    issue(1'b1, 1'b0, 4'h5, 8'h00, 1'b0, 8'h00);
    @(negedge clk);
    chk("abort_busy_rdwait", 64'(busy), 64'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_rvalid", 64'(rvalid1), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_rd_data1", 64'(rd_data1), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_rvalid_after", 64'(rvalid1), 64'd0);
    repeat (3) @(negedge clk);
    chk("sb_final", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
